// File: rtl/led_piece_shifter.sv
// led_piece_shifter -- drives one lit piece of PIECE_W contiguous LEDs across
// a COLS-wide RGB LED bar from raw push-buttons. Rising-edge commands shift
// the piece (saturating at the walls) or cycle its colour; a held shift
// button auto-repeats after REPEAT_DLY cycles, then every REPEAT_PER cycles.
// Optional build macro LED_PIECE_GRAVITY_EN adds a gravity row counter that
// lands the piece (returning it to the start column) after ROWS steps.

module led_piece_shifter #(
   parameter int COLS       = 8,
   parameter int PIECE_W    = 4,
   parameter int REPEAT_DLY = 25000000,
   parameter int REPEAT_PER = 5000000,
   parameter int ROWS       = 4,
   parameter int DROP_TICKS = 50000000,
   localparam int POS_W     = ((COLS - PIECE_W + 1) > 1) ? $clog2(COLS - PIECE_W + 1) : 1,
   localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       button,
   output logic [COLS-1:0]  rled,
   output logic [COLS-1:0]  gled,
   output logic [COLS-1:0]  bled,
   output logic [POS_W-1:0] pos,
   output logic [ROW_W-1:0] row,
   output logic             landed
);

   // ------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------
   localparam int               MAX_POS_I = COLS - PIECE_W;
   localparam logic [POS_W-1:0] MAX_POS   = POS_W'(MAX_POS_I);
   localparam logic [POS_W-1:0] RST_POS   = POS_W'(MAX_POS_I / 2);
   localparam logic [COLS-1:0]  BASE_MASK = {COLS{1'b1}} >> (COLS - PIECE_W);
   localparam logic [COLS-1:0]  RST_MASK  = BASE_MASK << RST_POS;

   // The repeat counter only ever counts up to (limit - 1).
   localparam int               REP_MAX   = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int               CNT_W     = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
   localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DLY - 1);
   localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(REPEAT_PER - 1);
   localparam bit               REPEAT_EN = (REPEAT_DLY != 0);

   localparam int BTN_RIGHT = 0;
   localparam int BTN_BACK  = 1;
   localparam int BTN_FWD   = 2;
   localparam int BTN_LEFT  = 3;

   typedef enum logic [1:0] {COL_BLUE, COL_RED, COL_GREEN} colour_e;
   typedef enum logic [1:0] {REP_IDLE, REP_DELAY, REP_PERIOD} rep_state_e;

   // Reject impossible configurations at elaboration time.
   if (COLS < PIECE_W || PIECE_W < 1 || REPEAT_DLY < 0 || REPEAT_PER < 1 ||
       ROWS < 1 || DROP_TICKS < 1) begin : g_param_check
      $error("led_piece_shifter: illegal parameter combination");
   end

   // ------------------------------------------------------------------
   // Signals
   // ------------------------------------------------------------------
   logic [3:0]       button_q;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [COLS-1:0]  mask_d;
   colour_e          colour_q;
   logic [COLS-1:0]  rled_q, gled_q, bled_q;
   rep_state_e       rep_state_q;
   logic [CNT_W-1:0] rep_cnt_q;

   logic [3:0]       rise;
   logic             one_hot;
   logic             accept;
   logic             shift_held;
   logic             rep_fire;
   logic             do_right;
   logic             do_left;
   logic             cmd_fwd;
   logic             cmd_back;
   logic             landing;

   // Returns the three bars {red, green, blue} with the mask on the active colour.
   function automatic logic [3*COLS-1:0] paint(input colour_e c, input logic [COLS-1:0] m);
      logic [COLS-1:0] zero;
      zero = '0;
      case (c)
         COL_RED:   paint = {m, zero, zero};
         COL_GREEN: paint = {zero, m, zero};
         default:   paint = {zero, zero, m};
      endcase
   endfunction

   // ------------------------------------------------------------------
   // Button sampling and command decode
   // ------------------------------------------------------------------

   // Previous-cycle button sample used for rising-edge detection.
   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) button_q <= '0;
      else     button_q <= button;
   end

   // Accept only a lone, freshly risen button; also flag a held lone shift button.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no latch can be inferred.
      rise       = button & ~button_q;
      one_hot    = $onehot(button);
      accept     = one_hot && (rise == button);
      shift_held = one_hot && (button == button_q) &&
                   (button[BTN_RIGHT] || button[BTN_LEFT]);
      rep_fire   = 1'b0;
      if (shift_held) begin
         case (rep_state_q)
            REP_DELAY:  rep_fire = (rep_cnt_q == DLY_LAST);
            REP_PERIOD: rep_fire = (rep_cnt_q == PER_LAST);
            default:    rep_fire = 1'b0;
         endcase
      end
      do_right = button[BTN_RIGHT] && (accept || rep_fire);
      do_left  = button[BTN_LEFT]  && (accept || rep_fire);
      cmd_fwd  = accept && button[BTN_FWD];
      cmd_back = accept && button[BTN_BACK];
   end

   // ------------------------------------------------------------------
   // Auto-repeat
   // ------------------------------------------------------------------

   // Repeat FSM: first repeat after REPEAT_DLY held cycles, then every REPEAT_PER.
   always_ff @(posedge clk) begin
      if (rst) begin
         rep_state_q <= REP_IDLE;
         rep_cnt_q   <= '0;
      end else if (REPEAT_EN && accept && (button[BTN_RIGHT] || button[BTN_LEFT])) begin
         rep_state_q <= REP_DELAY;
         rep_cnt_q   <= '0;
      end else if ((rep_state_q != REP_IDLE) && shift_held) begin
         if (rep_fire) begin
            rep_state_q <= REP_PERIOD;
            rep_cnt_q   <= '0;
         end else begin
            rep_cnt_q   <= rep_cnt_q + CNT_W'(1);
         end
      end else begin
         // Release, change, multi-bit press or colour button: stop repeating.
         rep_state_q <= REP_IDLE;
         rep_cnt_q   <= '0;
      end
   end

   // ------------------------------------------------------------------
   // Piece position
   // ------------------------------------------------------------------

   // Next position: a landing overrides any user shift; shifts saturate at the walls.
   always_comb begin
      pos_d = pos_q;
      if (landing) begin
         pos_d = RST_POS;
      end else if (do_right && (pos_q != '0)) begin
         pos_d = pos_q - POS_W'(1);
      end else if (do_left && (pos_q != MAX_POS)) begin
         pos_d = pos_q + POS_W'(1);
      end
      mask_d = BASE_MASK << pos_d;
   end

   // Position register.
   always_ff @(posedge clk) begin
      if (rst) pos_q <= RST_POS;
      else     pos_q <= pos_d;
   end

   // ------------------------------------------------------------------
   // Colour FSM with registered LED bars
   // ------------------------------------------------------------------

   // Colour cycling (fwd: B->R->G, back: B->G->R) and repainting of all bars.
   always_ff @(posedge clk) begin
      if (rst) begin
         colour_q                 <= COL_BLUE;
         {rled_q, gled_q, bled_q} <= {{(2*COLS){1'b0}}, RST_MASK};
      end else begin
         case (colour_q)
            COL_BLUE: begin
               if (cmd_fwd) begin
                  colour_q                 <= COL_RED;
                  {rled_q, gled_q, bled_q} <= paint(COL_RED, mask_d);
               end else if (cmd_back) begin
                  colour_q                 <= COL_GREEN;
                  {rled_q, gled_q, bled_q} <= paint(COL_GREEN, mask_d);
               end else begin
                  {rled_q, gled_q, bled_q} <= paint(COL_BLUE, mask_d);
               end
            end
            COL_RED: begin
               if (cmd_fwd) begin
                  colour_q                 <= COL_GREEN;
                  {rled_q, gled_q, bled_q} <= paint(COL_GREEN, mask_d);
               end else if (cmd_back) begin
                  colour_q                 <= COL_BLUE;
                  {rled_q, gled_q, bled_q} <= paint(COL_BLUE, mask_d);
               end else begin
                  {rled_q, gled_q, bled_q} <= paint(COL_RED, mask_d);
               end
            end
            COL_GREEN: begin
               if (cmd_fwd) begin
                  colour_q                 <= COL_BLUE;
                  {rled_q, gled_q, bled_q} <= paint(COL_BLUE, mask_d);
               end else if (cmd_back) begin
                  colour_q                 <= COL_RED;
                  {rled_q, gled_q, bled_q} <= paint(COL_RED, mask_d);
               end else begin
                  {rled_q, gled_q, bled_q} <= paint(COL_GREEN, mask_d);
               end
            end
            default: begin
               colour_q                 <= COL_BLUE;
               {rled_q, gled_q, bled_q} <= paint(COL_BLUE, mask_d);
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Gravity (optional)
   // ------------------------------------------------------------------
`ifdef LED_PIECE_GRAVITY_EN
   localparam int                TICK_W    = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DROP_TICKS - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);

   logic [TICK_W-1:0] tick_q;
   logic [ROW_W-1:0]  row_q;
   logic              landed_q;
   logic              wrap;

   assign wrap    = (tick_q == TICK_LAST);
   assign landing = wrap && (row_q == ROW_LAST);

   // Tick counter paces row steps; stepping past the last row lands the piece.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q   <= '0;
         row_q    <= '0;
         landed_q <= 1'b0;
      end else begin
         landed_q <= landing;
         if (wrap) begin
            tick_q <= '0;
            row_q  <= landing ? '0 : row_q + ROW_W'(1);
         end else begin
            tick_q <= tick_q + TICK_W'(1);
         end
      end
   end

   assign row    = row_q;
   assign landed = landed_q;
`else
   assign landing = 1'b0;
   assign row     = '0;
   assign landed  = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign rled = rled_q;
   assign gled = gled_q;
   assign bled = bled_q;
   assign pos  = pos_q;

endmodule
